// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response, redirect input and decoder-side op queue head.
interface fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic [31:0] op_value;
   logic [31:0] op_pc;
   logic        op_valid;
   logic        fetch_err;

   modport master (
      output imem_req, imem_addr, op_value, op_pc, op_valid, fetch_err,
      input  imem_ack, imem_rdata, redirect, redirect_pc, stall
   );

   modport slave (
      input  imem_req, imem_addr, op_value, op_pc, op_valid, fetch_err,
      output imem_ack, imem_rdata, redirect, redirect_pc, stall
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read, 2-entry {pc, instr} queue, redirect with in-flight flush.
// Define FETCH_MISALIGN_EN to trap misaligned redirect targets (sticky fetch_err, HALT until reset).
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic     clk,
   input  logic     rst_n,
   fetch_if.master  bus
);
   // state | meaning
   // IDLE  | first cycle after reset release, no request
   // FETCH | read request at imem_addr outstanding
   // HOLD  | queue full, fetching paused
   // FLUSH | waiting to discard a read made stale by a redirect
   // HALT  | misaligned redirect trapped, parked until reset
   typedef enum logic [2:0] {IDLE, FETCH, HOLD, FLUSH, HALT} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] pend_q, pend_d;
   logic [31:0] pc_q  [2];
   logic [31:0] ins_q [2];
   logic [1:0]  count_q, count_d;
   logic        err_q, err_d;
   logic        req, ack_ok, push, pop, clear, misalign;
   logic [31:0] rpc_al;

   assign req    = (state_q == FETCH) || (state_q == FLUSH);
   assign ack_ok = req && bus.imem_ack;
   assign rpc_al = bus.redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_EN
   assign misalign = |bus.redirect_pc[1:0];
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      pend_d  = pend_q;
      err_d   = err_q;
      push    = 1'b0;
      pop     = (count_q != 2'd0) && !bus.stall;
      clear   = 1'b0;

      case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            if (ack_ok) begin
               push   = 1'b1;
               addr_d = addr_q + 32'd4;
               if (!pop && count_q != 2'd0) state_d = HOLD;
            end
         end
         HOLD: begin
            if (count_q < 2'd2) state_d = FETCH;
         end
         FLUSH: begin
            if (bus.imem_ack) begin
               state_d = err_q ? HALT : FETCH;
               addr_d  = pend_q;
            end
         end
         default: ;
      endcase

      // Redirect wins over everything; a read still waiting for ack must be drained via FLUSH.
      if (bus.redirect && !err_q) begin
         clear = 1'b1;
         push  = 1'b0;
         pop   = 1'b0;
         if (misalign) begin
            err_d   = 1'b1;
            addr_d  = addr_q;
            state_d = (req && !bus.imem_ack) ? FLUSH : HALT;
         end else if (req && !bus.imem_ack) begin
            state_d = FLUSH;
            pend_d  = rpc_al;
            addr_d  = addr_q;
         end else begin
            state_d = FETCH;
            addr_d  = rpc_al;
         end
      end

      if (clear) count_d = 2'd0;
      else       count_d = count_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         addr_q   <= RESET_PC;
         pend_q   <= '0;
         err_q    <= 1'b0;
         count_q  <= 2'd0;
         pc_q[0]  <= '0;
         pc_q[1]  <= '0;
         ins_q[0] <= '0;
         ins_q[1] <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
         count_q <= count_d;
         if (pop) begin
            pc_q[0]  <= pc_q[1];
            ins_q[0] <= ins_q[1];
         end
         // New entry lands behind whatever survives this cycle's pop.
         if (push) begin
            if (count_q == 2'd1 && !pop) begin
               pc_q[1]  <= addr_q;
               ins_q[1] <= bus.imem_rdata;
            end else begin
               pc_q[0]  <= addr_q;
               ins_q[0] <= bus.imem_rdata;
            end
         end
      end
   end

   assign bus.imem_req  = req;
   assign bus.imem_addr = addr_q;
   assign bus.op_value  = ins_q[0];
   assign bus.op_pc     = pc_q[0];
   assign bus.op_valid  = (count_q != 2'd0);
`ifdef FETCH_MISALIGN_EN
   assign bus.fetch_err = err_q;
`else
   assign bus.fetch_err = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory/decoder stimulus against a queue-level model of the fetch stream.
module tb_fetch_unit;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_MISALIGN_EN
   localparam bit MISALIGN = 1'b1;
`else
   localparam bit MISALIGN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   fetch_if bus ();

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] q_pc [$];
   logic [31:0] exp_addr;
   logic [31:0] prev_addr;
   bit          flushing;
   bit          err_m;
   bit          prev_wait;
   int          idle_run;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
   endfunction

   function automatic bit traps(input logic [31:0] a);
      return (a[1:0] != 2'b00) && MISALIGN;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      bit halted;
      halted = err_m && !flushing;
      check_eq("op_valid", 32'(bus.op_valid), 32'(q_pc.size() != 0));
      if (q_pc.size() != 0) begin
         check_eq("op_pc", bus.op_pc, q_pc[0]);
         check_eq("op_value", bus.op_value, mem_word(q_pc[0]));
      end
      check_eq("fetch_err", 32'(bus.fetch_err), 32'(err_m));
      if (prev_wait) begin
         check_eq("addr_stable", bus.imem_addr, prev_addr);
         check_eq("req_held", 32'(bus.imem_req), 1);
      end
      if (flushing)
         check_eq("flush_req", 32'(bus.imem_req), 1);
      else if (halted || q_pc.size() == 2)
         check_eq("req_off", 32'(bus.imem_req), 0);
      else if (bus.imem_req)
         check_eq("imem_addr", bus.imem_addr, exp_addr);
      if (!bus.imem_req && !halted && q_pc.size() < 2) idle_run++;
      else idle_run = 0;
      check_eq("fetch_live", 32'(idle_run > 3), 0);
   endtask

   // One clock: check the current cycle, drive inputs, advance the model past the next edge.
   task automatic step(input bit ack, input bit stl, input bit rdr, input logic [31:0] rpc);
      bit          req, comp, popc;
      logic [31:0] addr;
      check_outputs();
      req  = bus.imem_req;
      addr = bus.imem_addr;
      bus.imem_ack    = ack;
      bus.imem_rdata  = ack ? mem_word(addr) : $urandom;
      bus.stall       = stl;
      bus.redirect    = rdr;
      bus.redirect_pc = rpc;
      comp      = req && ack;
      popc      = (q_pc.size() != 0) && !stl;
      prev_wait = req && !ack;
      prev_addr = addr;
      if (rdr && !err_m) begin
         q_pc.delete();
         flushing = req && !ack;
         if (traps(rpc)) err_m = 1'b1;
         else exp_addr = rpc & 32'hFFFF_FFFC;
      end else begin
         if (popc) void'(q_pc.pop_front());
         if (comp && flushing) flushing = 1'b0;
         else if (comp) begin
            q_pc.push_back(exp_addr);
            exp_addr = exp_addr + 32'd4;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset(input int cycles);
      rst_n           = 1'b0;
      bus.imem_ack    = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      #1;
      check_eq("rst_req", 32'(bus.imem_req), 0);
      check_eq("rst_addr", bus.imem_addr, RST_PC);
      check_eq("rst_valid", 32'(bus.op_valid), 0);
      check_eq("rst_value", bus.op_value, 0);
      check_eq("rst_pc", bus.op_pc, 0);
      check_eq("rst_err", 32'(bus.fetch_err), 0);
      repeat (cycles) @(negedge clk);
      rst_n = 1'b1;
      q_pc.delete();
      exp_addr  = RST_PC;
      flushing  = 1'b0;
      err_m     = 1'b0;
      prev_wait = 1'b0;
      idle_run  = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          first_v;
      logic [31:0] head;
      bit          seen;
      bit          rdr;
      logic [31:0] rpc;
      int          ack_tab   [3] = '{100, 55, 30};
      int          stall_tab [3] = '{0, 40, 10};

      bus.imem_ack    = 1'b0;
      bus.imem_rdata  = 32'h0;
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      @(negedge clk);
      do_reset(3);

      // zero-wait streaming from reset
      first_v = 0;
      for (int i = 1; i <= 10; i++) begin
         if (bus.op_valid && first_v == 0) first_v = i;
         if (i >= 2) check_eq("stream_req", 32'(bus.imem_req), 1);
         step(1'b1, 1'b0, 1'b0, 32'h0);
      end
      check_eq("first_valid_cycle", first_v, 3);
      check_eq("stream_addr", bus.imem_addr, 32'h24);

      // decoder stalled: queue fills and fetching pauses, then resumes two words past head
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
      check_eq("hold_req", 32'(bus.imem_req), 0);
      head = q_pc[0];
      seen = 1'b0;
      for (int i = 0; i < 6 && !seen; i++) begin
         if (bus.imem_req) begin
            seen = 1'b1;
            check_eq("resume_addr", bus.imem_addr, head + 32'd8);
         end else begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
         end
      end
      check_eq("resume_seen", 32'(seen), 1);

      // redirect while 0x20 waits on a slow ack
      step(1'b1, 1'b0, 1'b1, 32'h20);
      check_eq("pre_flush_addr", bus.imem_addr, 32'h20);
      step(1'b0, 1'b0, 1'b1, 32'h100);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check_eq("flush_new_addr", bus.imem_addr, 32'h100);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check_eq("flush_first_valid", 32'(bus.op_valid), 1);
      check_eq("flush_first_pc", bus.op_pc, 32'h100);

      // redirect against a full queue, then against an ack with pop
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b1, 32'h200);
      check_eq("rdr_full_valid", 32'(bus.op_valid), 0);
      check_eq("rdr_full_addr", bus.imem_addr, 32'h200);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b1, 32'h300);
      check_eq("rdr_ack_valid", 32'(bus.op_valid), 0);
      check_eq("rdr_ack_addr", bus.imem_addr, 32'h300);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check_eq("rdr_ack_pc", bus.op_pc, 32'h300);

      // address wrap
      step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
      check_eq("wrap_addr", bus.imem_addr, 32'h4);

      // misaligned redirect target
      step(1'b1, 1'b0, 1'b1, 32'h102);
`ifdef FETCH_MISALIGN_EN
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 32'h40);
      check_eq("halt_req", 32'(bus.imem_req), 0);
      check_eq("halt_err", 32'(bus.fetch_err), 1);
      do_reset(2);
`else
      check_eq("align_addr", bus.imem_addr, 32'h100);
`endif

      // reset in the middle of an outstanding request, ack held high through reset
      step(1'b0, 1'b0, 1'b1, 32'h40);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      do_reset(2);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check_eq("post_rst_pc", bus.op_pc, RST_PC);

      // randomized traffic at three ack/stall mixes
      for (int ph = 0; ph < 3; ph++) begin
         for (int i = 0; i < 600; i++) begin
            rdr = ($urandom_range(0, 99) < 4);
            rpc = $urandom & 32'h0000_0FFC;
            if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            if ((err_m && !flushing && $urandom_range(0, 9) == 0) || $urandom_range(0, 499) == 0)
               do_reset(2);
            else
               step($urandom_range(0, 99) < ack_tab[ph], $urandom_range(0, 99) < stall_tab[ph], rdr, rpc);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
